booth_product_accumulator: RTL
==============================

// Module: booth_product_accumulator
// PURPOSE
//  Sequential accumulator directly downstream of the combinational radix-4 Booth multiplier.
//  Registers each signed product P, sign-extends it and adds it to a running sum. Sums a
//  frame of products delimited by in_last, then presents the total to the consumer.
//  Used for dot-products and MAC reduction. Valid/ready handshakes on both sides.
// PARAMETERS
//  OUT_WIDTH  8   width of the incoming two's-complement product (matches multiplier P)
//  ACC_WIDTH  16  accumulator/result width; must be >= OUT_WIDTH
//  CNT_WIDTH  8   width of the per-frame beat counter
//  SATURATE   1   1: clamp sum at signed min/max on overflow; 0: two's-complement wrap
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          in_prod/in_last valid this cycle
//  in_ready   out  1          accumulator can accept a beat this cycle
//  in_prod    in   OUT_WIDTH  signed product from the Booth multiplier
//  in_last    in   1          this beat closes the current frame
//  out_valid  out  1          out_sum/out_count/out_ovf hold a finished frame result
//  out_ready  in   1          consumer accepts the result this cycle
//  out_sum    out  ACC_WIDTH  signed frame sum
//  out_count  out  CNT_WIDTH  number of beats in the frame (saturates at all-ones)
//  out_ovf    out  1          sticky: a signed overflow occurred during the frame
// BEHAVIOUR
//  Reset: state=ACCUM, acc=0, count=0, ovf=0, out_valid=0, out_sum=0, out_count=0,
//   out_ovf=0, in_ready=1 in the first cycle after reset.
//  Handshakes: a beat is accepted when in_valid&in_ready. A result is consumed when
//   out_valid&out_ready. out_sum/out_count/out_ovf stay stable while out_valid=1 and
//   out_ready=0. in_ready is registered-state-driven (no comb path from out_ready).
//  FSM with two states:
//   ACCUM: in_ready=1, out_valid=0. On an accepted beat: ext = sign-extend(in_prod) to
//    ACC_WIDTH; nsum = acc+ext, computed at ACC_WIDTH+1 bits. Overflow = top two bits of
//    nsum differ. On overflow: ovf<=1; if SATURATE, the sum clamps to 0111..1 (positive)
//    or 1000..0 (negative), else it wraps. count <= count+1, holding at 2^CNT_WIDTH-1.
//    If in_last=0: acc/count/ovf update and the FSM stays in ACCUM.
//    If in_last=1: out_sum<=new sum, out_count<=new count, out_ovf<=new ovf. Then
//    acc<=0, count<=0, ovf<=0, and the FSM moves to HOLD.
//   HOLD: in_ready=0, out_valid=1. On out_ready: out_valid<=0, back to ACCUM. in_ready
//    rises the next cycle (one bubble per frame).
//  Latency: the result is visible with out_valid=1 on the cycle after the in_last beat
//   is accepted.
//  Single-beat frame (in_last on the first beat): out_sum=sext(in_prod), out_count=1.
//  in_valid while in HOLD: ignored (in_ready=0); the producer must hold the beat.
//  Gaps (in_valid=0) in ACCUM: no state change.
//  Saturated accumulator: later beats still add from the clamped value. Example: at max,
//   a negative beat lowers it.
//  Reset mid-frame or while in HOLD: the partial sum and any pending result are
//   discarded, and all outputs return to reset values on the next edge.
//  rst has priority over every handshake in the same cycle.
// TESTING
//  T1 reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_sum=0,
//   no beat counted.
//  T2 basic frame (defaults): beats 8'h15(+21), 8'hC8(-56, last) -> next cycle
//   out_valid=1, out_sum=16'hFFDD(-35), out_count=2, out_ovf=0.
//  T3 backpressure: after T2 hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0,
//   outputs stable. Raise out_ready -> out_valid falls; in_ready=1 next cycle;
//   the next frame starts from acc=0.
//  T4 saturation (ACC_WIDTH=8, SATURATE=1): beats 8'h40, 8'h40(last) -> out_sum=8'h7F,
//   out_ovf=1. With SATURATE=0 -> out_sum=8'h80, out_ovf=1.
//  T5 reset mid-frame: accept 8'h10, 8'h10, pulse rst, then 8'h05(last) -> out_sum=16'h0005,
//   out_count=1.
//  T6 end-to-end: drive the multiplier over all 256 A,B pairs (4-bit signed) in frames of 4
//   with random in_valid/out_ready gaps -> each out_sum equals the reference model's sum
//   of signed A*B.

Source files
------------

// File: rtl/booth_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : booth_product_accumulator
// Description : Frame accumulator placed after the radix-4 Booth multiplier.
//               Each accepted beat carries one signed product; it is
//               sign-extended to ACC_WIDTH and added to a running sum.
//               The beat flagged by in_last closes the frame: the total,
//               the beat count and a sticky overflow flag are latched into
//               the result registers and presented on the output handshake.
//               Overflow either clamps to the signed extremes or wraps,
//               selected by SATURATE.
// Ports       : clk        rising-edge clock
//               rst        synchronous active-high reset
//               in_valid   producer beat valid
//               in_ready   accumulator can accept a beat (state driven only)
//               in_prod    signed product, OUT_WIDTH bits
//               in_last    beat closes the current frame
//               out_valid  frame result is held on out_sum/out_count/out_ovf
//               out_ready  consumer takes the result
//               out_sum    signed frame sum, ACC_WIDTH bits
//               out_count  beats in the frame, saturating at all-ones
//               out_ovf    a signed overflow happened somewhere in the frame
// Revision    : 1.0  initial release
// ============================================================================
module booth_product_accumulator #(
  parameter int OUT_WIDTH = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OUT_WIDTH-1:0] in_prod,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  // Two-state controller: collecting beats, or holding a finished result.
  localparam logic [0:0] c_ACCUM = 1'b0;
  localparam logic [0:0] c_HOLD  = 1'b1;

  localparam logic [ACC_WIDTH-1:0] c_SUM_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] c_SUM_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]           state_q,     state_d;
  logic [ACC_WIDTH-1:0] acc_q,       acc_d;
  logic [CNT_WIDTH-1:0] count_q,     count_d;
  logic                 ovf_q,       ovf_d;
  logic [ACC_WIDTH-1:0] out_sum_q,   out_sum_d;
  logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                 out_ovf_q,   out_ovf_d;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH:0]   w_nsum;
  logic                 w_ovf;
  logic [ACC_WIDTH-1:0] w_sum_new;
  logic [CNT_WIDTH-1:0] w_count_new;
  logic                 w_ovf_new;
  logic                 w_accept;
  logic                 w_consume;

  // A zero-width replication is illegal, so the equal-width case is split out.
  generate
    if (ACC_WIDTH > OUT_WIDTH) begin : g_ext_wide
      assign w_ext = {{(ACC_WIDTH-OUT_WIDTH){in_prod[OUT_WIDTH-1]}}, in_prod};
    end else begin : g_ext_equal
      assign w_ext = in_prod[ACC_WIDTH-1:0];
    end
  endgenerate

  // One guard bit: the true sign lives in bit ACC_WIDTH, so a disagreement
  // with bit ACC_WIDTH-1 means the result does not fit in ACC_WIDTH bits.
  assign w_nsum = {acc_q[ACC_WIDTH-1], acc_q} + {w_ext[ACC_WIDTH-1], w_ext};
  assign w_ovf  = w_nsum[ACC_WIDTH] ^ w_nsum[ACC_WIDTH-1];

  always_comb begin
    w_sum_new = w_nsum[ACC_WIDTH-1:0];
    if (w_ovf && (SATURATE != 0)) begin
      // Clamp toward the direction of the true (guard-bit) sign.
      w_sum_new = w_nsum[ACC_WIDTH] ? c_SUM_MIN : c_SUM_MAX;
    end
  end

  assign w_count_new = (count_q == c_CNT_MAX) ? count_q : count_q + 1'b1;
  assign w_ovf_new   = ovf_q | w_ovf;

  // in_ready depends on registered state only; no path from out_ready.
  assign in_ready  = (state_q == c_ACCUM);
  assign out_valid = (state_q == c_HOLD);

  assign w_accept  = in_valid  & in_ready;
  assign w_consume = out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      c_ACCUM: begin
        if (w_accept) begin
          if (in_last) begin
            // Publish the closed frame and clear the running state so the
            // next frame starts from zero once the result is taken.
            out_sum_d   = w_sum_new;
            out_count_d = w_count_new;
            out_ovf_d   = w_ovf_new;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            state_d     = c_HOLD;
          end else begin
            acc_d   = w_sum_new;
            count_d = w_count_new;
            ovf_d   = w_ovf_new;
          end
        end
      end
      c_HOLD: begin
        // Result registers are left untouched so they stay stable under
        // backpressure.
        if (w_consume) begin
          state_d = c_ACCUM;
        end
      end
      default: begin
        state_d = c_ACCUM;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire
